// File: rtl/ddr3_port_arbiter.sv
// rtl/ddr3_port_arbiter.sv - two-port arbiter feeding DDR3 request FIFOs, in-order read return routing
// Define ARB_FIXED_PRIO_EN to give port 1 fixed priority instead of round-robin.
module ddr3_port_arbiter #(
  parameter int ADDRESS_WIDTH   = 32,
  parameter int DATA_WIDTH      = 128,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  en,
  input  logic [1:0]                            req,
  input  logic [1:0]                            we,
  input  logic [2*ADDRESS_WIDTH-1:0]            addr,
  input  logic [2*DATA_WIDTH-1:0]               wdata,
  output logic [1:0]                            gnt,
  output logic [1:0]                            rsp_valid,
  output logic [DATA_WIDTH-1:0]                 rsp_data,
  output logic                                  wr_fifo_push,
  output logic [ADDRESS_WIDTH-1:0]              wr_fifo_addr,
  output logic [DATA_WIDTH-1:0]                 wr_fifo_data,
  input  logic                                  wr_fifo_full,
  output logic                                  rd_fifo_push,
  output logic [ADDRESS_WIDTH-1:0]              rd_fifo_addr,
  input  logic                                  rd_fifo_full,
  input  logic                                  ret_fifo_empty,
  input  logic [DATA_WIDTH-1:0]                 ret_fifo_data,
  output logic                                  ret_fifo_pop,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]  outstanding,
  output logic                                  err_orphan
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = $clog2(MAX_OUTSTANDING);

  typedef enum logic {ARB, ISSUE} state_t;

  state_t                   state, state_next;
  logic [1:0]               elig;
  logic                     win;
  logic [ADDRESS_WIDTH-1:0] l_addr;
  logic [DATA_WIDTH-1:0]    l_wdata;
  logic                     l_win;
  logic                     tag_mem [MAX_OUTSTANDING];
  logic [PW-1:0]            tag_wr_ptr, tag_rd_ptr;
  logic [CW-1:0]            tag_count;
  logic                     tag_push, tag_pop;
`ifndef ARB_FIXED_PRIO_EN
  logic                     rr_ptr;
`endif

  always_comb begin
    elig = 2'b00;
    for (int p = 0; p < 2; p++) begin
      if (req[p] && en) begin
        if (we[p]) elig[p] = !wr_fifo_full;
        else       elig[p] = !rd_fifo_full && (tag_count < CW'(MAX_OUTSTANDING));
      end
    end
  end

  always_comb begin
    state_next = state;
    gnt        = 2'b00;
`ifdef ARB_FIXED_PRIO_EN
    win = elig[1];
`else
    win = (elig == 2'b11) ? rr_ptr : elig[1];
`endif
    case (state)
      ARB: begin
        if (!rst && (|elig)) begin
          gnt[win]   = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE:   state_next = ARB;
      default: state_next = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ARB;
      l_addr       <= '0;
      l_wdata      <= '0;
      l_win        <= 1'b0;
      wr_fifo_push <= 1'b0;
      rd_fifo_push <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      rr_ptr       <= 1'b0;
`endif
    end else begin
      state        <= state_next;
      wr_fifo_push <= 1'b0;
      rd_fifo_push <= 1'b0;
      if (|gnt) begin
        l_addr       <= win ? addr[2*ADDRESS_WIDTH-1:ADDRESS_WIDTH] : addr[ADDRESS_WIDTH-1:0];
        l_wdata      <= win ? wdata[2*DATA_WIDTH-1:DATA_WIDTH]      : wdata[DATA_WIDTH-1:0];
        l_win        <= win;
        wr_fifo_push <= we[win];
        rd_fifo_push <= !we[win];
`ifndef ARB_FIXED_PRIO_EN
        rr_ptr       <= ~win;
`endif
      end
    end
  end

  assign wr_fifo_addr = l_addr;
  assign wr_fifo_data = l_wdata;
  assign rd_fifo_addr = l_addr;

  // Return path runs every cycle regardless of the grant FSM.
  assign ret_fifo_pop = !ret_fifo_empty && !rst;
  assign tag_push     = rd_fifo_push;
  assign tag_pop      = ret_fifo_pop && (tag_count != '0);
  assign outstanding  = tag_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_wr_ptr <= '0;
      tag_rd_ptr <= '0;
      tag_count  <= '0;
      rsp_valid  <= 2'b00;
      rsp_data   <= '0;
      err_orphan <= 1'b0;
    end else begin
      rsp_valid <= 2'b00;
      rsp_data  <= '0;
      if (tag_pop) begin
        rsp_valid[tag_mem[tag_rd_ptr]] <= 1'b1;
        rsp_data                       <= ret_fifo_data;
        tag_rd_ptr                     <= tag_rd_ptr + 1'b1;
      end
      if (ret_fifo_pop && (tag_count == '0)) err_orphan <= 1'b1;
      if (tag_push) begin
        tag_mem[tag_wr_ptr] <= l_win;
        tag_wr_ptr          <= tag_wr_ptr + 1'b1;
      end
      tag_count <= tag_count + CW'(tag_push) - CW'(tag_pop);
    end
  end

endmodule

// File: doc/ddr3_port_arbiter.md
Name: ddr3_port_arbiter

Overview:
Shares the DDR3 controller's request FIFOs between two requesters: port 0 (instruction fetch) and port 1 (data memory).
It pushes accepted writes into the write FIFO and accepted reads into the read-request FIFO. A tag queue records which port issued each read, so read returns are routed back to the correct port in order.
It sits between the core's memory ports and the DDR3 controller FSM's FIFO front-end.

Parameters:
ADDRESS_WIDTH, 32, byte address width on all ports and FIFOs
DATA_WIDTH, 128, data width (one DDR3 burst)
MAX_OUTSTANDING, 8, maximum in-flight reads; also the tag queue depth (power of 2, ≥2)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous reset, active-high
en  in  1  when low: no new grants; return draining continues
req  in  2  per-port request; held with attributes until gnt
we  in  2  per-port 1=write, 0=read
addr  in  2*ADDRESS_WIDTH  per-port address; port p at [p*AW +: AW]
wdata  in  2*DATA_WIDTH  per-port write data
gnt  out  2  one-hot acceptance pulse (combinational)
rsp_valid  out  2  one-cycle read-data pulse per port (registered)
rsp_data  out  DATA_WIDTH  read data; shared by both ports, qualified by rsp_valid
wr_fifo_push  out  1  write FIFO push (registered)
wr_fifo_addr  out  ADDRESS_WIDTH  write address
wr_fifo_data  out  DATA_WIDTH  write data
wr_fifo_full  in  1  write FIFO full
rd_fifo_push  out  1  read-request FIFO push (registered)
rd_fifo_addr  out  ADDRESS_WIDTH  read address
rd_fifo_full  in  1  read-request FIFO full
ret_fifo_empty  in  1  read-return FIFO empty (first-word fall-through)
ret_fifo_data  in  DATA_WIDTH  read-return head data
ret_fifo_pop  out  1  read-return pop (combinational)
outstanding  out  $clog2(MAX_OUTSTANDING+1)  in-flight read count
err_orphan  out  1  sticky: a return arrived with no tag queued

Behaviour:
- Reset (rst=1 at a clock edge) sets:
  - state ARB, rr_ptr=0, tag queue empty, outstanding=0, err_orphan=0;
  - all registered outputs 0 (gnt=0, ret_fifo_pop=0 while rst is high).
- Reset mid-operation discards all tags. Downstream FIFOs are flushed by their owner on the same reset.
- Eligibility of port p:
  - common: req[p] && en;
  - write: also !wr_fifo_full;
  - read: also !rd_fifo_full && outstanding < MAX_OUTSTANDING.
- State ARB:
  - If any port is eligible, pick the winner. If both are eligible, the winner is rr_ptr.
  - gnt[winner]=1 this cycle. Latch we/addr/wdata, latch winner ID, set rr_ptr = ~winner, go to ISSUE.
  - If none is eligible, stay in ARB with gnt=0.
- State ISSUE (exactly 1 cycle), then return to ARB:
  - write: wr_fifo_push=1 with latched addr/data;
  - read: rd_fifo_push=1, and push the winner ID into the tag queue.
- Throughput: at most one request per 2 cycles. Fullness is sampled in ARB. This block is the only pusher, so the push in ISSUE never overflows.
- Return path, independent of the FSM:
  - ret_fifo_pop = !ret_fifo_empty && !rst. This pops every cycle while data is present.
  - If the tag queue is non-empty: pop the head tag. Next cycle, rsp_valid[tag]=1 and rsp_data=ret_fifo_data (1-cycle latency).
  - If the tag queue is empty: data is dropped, err_orphan←1 (sticky until rst), rsp_valid stays 0.
- outstanding counter:
  - +1 on a read push in ISSUE;
  - −1 on a tagged return pop;
  - both in the same cycle: unchanged;
  - never exceeds MAX_OUTSTANDING.
- Tag queue pointers wrap modulo MAX_OUTSTANDING.
- Responses are strictly in issue order across both ports.
- rsp_data is 0 whenever rsp_valid==0.
- en falling during ISSUE: the pending push still completes. New grants are blocked from the next ARB cycle.
- Address passes through unmodified. Callers present 16-byte-aligned addresses.

Optional Feature:
Macro ARB_FIXED_PRIO_EN.
- Defined: port 1 (data) always wins when both ports are eligible; rr_ptr is unused.
- Undefined: round-robin as above.
- Single-requester behaviour is identical in both builds.

Test Plan:
1. Reset, port0 read addr=0x100 → gnt[0] cycle 1, rd_fifo_push cycle 2 with rd_fifo_addr=0x100, outstanding=1. Then return 0xA5..A5 → rsp_valid[0]=1 with rsp_data=0xA5..A5 one cycle after pop, outstanding=0.
2. Both ports request reads continuously → grants alternate 0,1,0,1 (round-robin). With ARB_FIXED_PRIO_EN defined → gnt[1] on every grant.
3. 8 reads issued with no returns → outstanding=8. The 9th read gets no gnt until one return pops, then it is granted the following ARB cycle.
4. Port1 write with wr_fifo_full=1 for 5 cycles → gnt[1]=0 throughout. Release full → gnt then wr_fifo_push with addr/data matching the request.
5. Interleaved reads p0,p1,p0 with returns D0,D1,D2 → rsp_valid order 0,1,0 carrying D0,D1,D2.
6. Inject a return with no outstanding read → ret_fifo_pop=1, no rsp_valid, err_orphan=1 until rst. rst mid-burst → outstanding=0 and err_orphan=0 next cycle.
